// File: rtl/tick_divider_bank.sv
// Prescaled tick generator feeding a bank of independent divide-by-(div+1) channels.
// Optional build macro PHASE_SYNC_EN adds a 'sync' input that re-phases the whole bank.
module tick_divider_bank #(
  parameter int NUM_CH   = 2,
  parameter int PRESCALE = 50000,
  parameter int DIV_W    = 10,
  parameter int DIV_INIT = 1023,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PS_W    = $clog2(PRESCALE)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef PHASE_SYNC_EN
  input  logic              sync,
`endif
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic              tick,
  output logic [NUM_CH-1:0] ch_pulse,
  output logic [NUM_CH-1:0] led
);

  logic [PS_W-1:0]  r_presc;
  logic             r_tick;
  logic [DIV_W-1:0] r_cnt    [NUM_CH];
  logic [DIV_W-1:0] r_div    [NUM_CH];
  logic [DIV_W-1:0] r_sh_div [NUM_CH];
  logic [NUM_CH-1:0] r_mode;
  logic [NUM_CH-1:0] r_sh_mode;
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_led;
  logic [NUM_CH-1:0] r_pulse;

  logic [NUM_CH-1:0] w_term;
  logic [NUM_CH-1:0] w_wr;
  logic [NUM_CH-1:0] w_apply;
  logic              w_ready;
  logic              w_presc_last;

  assign w_presc_last = (r_presc == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end
`ifdef PHASE_SYNC_EN
    else if (sync) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end
`endif
    else begin
      r_tick  <= w_presc_last;
      r_presc <= w_presc_last ? '0 : r_presc + 1'b1;
    end
  end

  // Out-of-range channel numbers match no channel, so they read ready and are dropped.
  always_comb begin
    w_ready = 1'b1;
    for (int n = 0; n < NUM_CH; n++) begin
      if (cfg_ch == CH_W'(n)) w_ready = ~r_pend[n];
    end
  end

  always_comb begin
    w_term  = '0;
    w_wr    = '0;
    w_apply = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      w_term[n]  = r_tick & ch_en[n] & (r_cnt[n] == r_div[n]);
      w_wr[n]    = cfg_valid & w_ready & (cfg_ch == CH_W'(n));
      w_apply[n] = r_pend[n] & (w_term[n] | ~ch_en[n]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_CH; n++) begin
        r_cnt[n]    <= '0;
        r_div[n]    <= DIV_W'(DIV_INIT);
        r_sh_div[n] <= DIV_W'(DIV_INIT);
      end
      r_mode    <= '0;
      r_sh_mode <= '0;
      r_pend    <= '0;
      r_led     <= '0;
      r_pulse   <= '0;
    end
`ifdef PHASE_SYNC_EN
    else if (sync) begin
      for (int n = 0; n < NUM_CH; n++) begin
        r_cnt[n]   <= '0;
        r_led[n]   <= 1'b0;
        r_pulse[n] <= 1'b0;
        if (r_pend[n]) begin
          r_div[n]  <= r_sh_div[n];
          r_mode[n] <= r_sh_mode[n];
          r_pend[n] <= 1'b0;
        end else if (w_wr[n]) begin
          r_sh_div[n]  <= cfg_div;
          r_sh_mode[n] <= cfg_mode;
          r_pend[n]    <= 1'b1;
        end
      end
    end
`endif
    else begin
      for (int n = 0; n < NUM_CH; n++) begin
        r_pulse[n] <= w_term[n];
        if (!ch_en[n]) begin
          r_cnt[n] <= '0;
          r_led[n] <= 1'b0;
        end else if (r_tick) begin
          if (w_term[n]) begin
            r_cnt[n] <= '0;
            r_led[n] <= r_mode[n] ? 1'b1 : ~r_led[n];
          end else begin
            r_cnt[n] <= r_cnt[n] + 1'b1;
            if (r_mode[n]) r_led[n] <= 1'b0;
          end
        end
        // A transfer can only land while nothing is pending, so it never applies on its own edge.
        if (w_apply[n]) begin
          r_div[n]  <= r_sh_div[n];
          r_mode[n] <= r_sh_mode[n];
          r_pend[n] <= 1'b0;
          if (r_sh_mode[n] != r_mode[n]) r_led[n] <= 1'b0;
        end else if (w_wr[n]) begin
          r_sh_div[n]  <= cfg_div;
          r_sh_mode[n] <= cfg_mode;
          r_pend[n]    <= 1'b1;
        end
      end
    end
  end

  assign cfg_ready = w_ready;
  assign tick      = r_tick;
  assign ch_pulse  = r_pulse;
  assign led       = r_led;

endmodule

// File: tb/tb_tick_divider_bank.sv
// Directed bench for tick_divider_bank at PRESCALE=4, DIV_W=4, DIV_INIT=2, NUM_CH=2.
// Edge numbers count rising edges after reset release; sampling is on the falling edge.
module tb_tick_divider_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] ch_en = 2'b00;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [0:0] cfg_ch = 1'b0;
  logic [3:0] cfg_div = 4'd0;
  logic       cfg_mode = 1'b0;
  logic       tick;
  logic [1:0] ch_pulse;
  logic [1:0] led;
`ifdef PHASE_SYNC_EN
  logic       sync = 1'b0;
`endif

  int n_vec  = 0;
  int n_err  = 0;
  int n_edge = 0;
  int base   = 0;

  tick_divider_bank #(
    .NUM_CH(2), .PRESCALE(4), .DIV_W(4), .DIV_INIT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef PHASE_SYNC_EN
    .sync(sync),
`endif
    .ch_en(ch_en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_mode(cfg_mode),
    .tick(tick),
    .ch_pulse(ch_pulse),
    .led(led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) n_edge++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic goto(input int k);
    while (n_edge - base < k) @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ch_en = 2'b11;
    repeat (3) @(negedge clk);
    chk("rst_tick", tick, 0);
    chk("rst_led", led, 0);
    chk("rst_pulse", ch_pulse, 0);
    chk("rst_ready", cfg_ready, 1);
    rst = 1'b0;
    base = n_edge;

    // Free-running: tick every 4 clocks, both channels terminate every 3 ticks
    goto(3);  chk("tick_e3", tick, 0);
    goto(4);  chk("tick_e4", tick, 1);
    goto(5);  chk("tick_e5", tick, 0);
    goto(12); chk("led_e12", led, 2'b00); chk("pulse_e12", ch_pulse, 2'b00);
    goto(13); chk("led_e13", led, 2'b11); chk("pulse_e13", ch_pulse, 2'b11);
    goto(14); chk("led_e14", led, 2'b11); chk("pulse_e14", ch_pulse, 2'b00);
    goto(24); chk("led_e24", led, 2'b11);
    goto(25); chk("led_e25", led, 2'b00); chk("pulse_e25", ch_pulse, 2'b11);

    // ch1 -> div 0, pulse mode
    goto(26);
    cfg_ch = 1'b1; cfg_div = 4'd0; cfg_mode = 1'b1; cfg_valid = 1'b1;
    #1 chk("ready_pre_wr1", cfg_ready, 1);
    goto(27);
    cfg_valid = 1'b0;
    #1 chk("ready_busy_ch1", cfg_ready, 0);
    cfg_ch = 1'b0;
    #1 chk("ready_free_ch0", cfg_ready, 1);
    cfg_ch = 1'b1;
    goto(36); chk("ready_e36", cfg_ready, 0); chk("led_e36", led, 2'b00);
    goto(37); chk("led_e37", led, 2'b01); chk("pulse_e37", ch_pulse, 2'b11);
              chk("ready_e37", cfg_ready, 1);
    goto(40); chk("led_e40", led, 2'b01); chk("pulse_e40", ch_pulse, 2'b00);
    goto(41); chk("led_e41", led, 2'b11); chk("pulse_e41", ch_pulse, 2'b10);
    goto(44); chk("led_e44", led, 2'b11); chk("pulse_e44", ch_pulse, 2'b00);
    goto(45); chk("pulse_e45", ch_pulse, 2'b10);

    // ch0 disabled for edges 46..55
    ch_en = 2'b10;
    goto(46); chk("led_dis_e46", led, 2'b10);
    goto(49); chk("pulse0_dis_e49", ch_pulse[0], 0);
    goto(55); ch_en = 2'b11;
    goto(64); chk("pulse0_e64", ch_pulse[0], 0); chk("led0_e64", led[0], 0);
    goto(65); chk("pulse0_e65", ch_pulse[0], 1); chk("led0_e65", led[0], 1);

    // ch0 -> div 5, accepted on the edge of its own terminal event
    goto(76);
    cfg_ch = 1'b0; cfg_div = 4'd5; cfg_mode = 1'b0; cfg_valid = 1'b1;
    #1 chk("ready_pre_wr0", cfg_ready, 1);
    goto(77);
    cfg_valid = 1'b0;
    chk("pulse0_e77", ch_pulse[0], 1); chk("led0_e77", led[0], 0);
    chk("ready_busy_e77", cfg_ready, 0);
    goto(89);  chk("pulse0_e89", ch_pulse[0], 1); chk("led0_e89", led[0], 1);
               chk("ready_e89", cfg_ready, 1);
    goto(101); chk("pulse0_e101", ch_pulse[0], 0); chk("led0_e101", led[0], 1);
    goto(112); chk("pulse0_e112", ch_pulse[0], 0);
    goto(113); chk("pulse0_e113", ch_pulse[0], 1); chk("led0_e113", led[0], 0);

    // Pending ch0 write then asynchronous reset mid-cycle
    goto(114);
    cfg_ch = 1'b0; cfg_div = 4'd3; cfg_mode = 1'b1; cfg_valid = 1'b1;
    goto(115);
    cfg_valid = 1'b0;
    chk("ready_busy_e115", cfg_ready, 0);
    chk("led1_pre_rst", led[1], 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tick", tick, 0);
    chk("arst_led", led, 2'b00);
    chk("arst_pulse", ch_pulse, 2'b00);
    chk("arst_ready", cfg_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    base = n_edge;
    goto(12); chk("rr_led_e12", led, 2'b00); chk("rr_pulse_e12", ch_pulse, 2'b00);
    goto(13); chk("rr_led_e13", led, 2'b11); chk("rr_pulse_e13", ch_pulse, 2'b11);

`ifdef PHASE_SYNC_EN
    goto(14); ch_en = 2'b01;
    goto(18); ch_en = 2'b11;
    goto(20); chk("led_pre_sync", led, 2'b01); sync = 1'b1;
    goto(21); sync = 1'b0; chk("led_sync", led, 2'b00);
    goto(33); chk("pulse_sync_e33", ch_pulse, 2'b00);
    goto(34); chk("pulse_sync_e34", ch_pulse, 2'b11);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
